// File: rtl/ipu_pkg.sv
// ipu_pkg: constants and types shared by the IPU resize stage and its
// downstream frame packer.
//   IPU_RESIZE_W / IPU_RESIZE_H : resized binary image geometry
//   rd_state_t                  : replay FSM encoding (IDLE, RD, SEND)
package ipu_pkg;

    localparam int unsigned IPU_RESIZE_W = 64;
    localparam int unsigned IPU_RESIZE_H = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        SEND = 2'd2
    } rd_state_t;

endpackage

// File: rtl/resize_frame_packer_ram.sv
// sdp_ram_1r1w: simple dual-port RAM, one write port and one read port.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   we, wr_addr, wr_data : write port; a same-address read returns old data
//   rd_en, rd_addr       : read request; rd_data updates one cycle later
//   rd_data              : registered read data, held while rd_en is low
module sdp_ram_1r1w #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/resize_frame_packer.sv
// resize_frame_packer: packs the serial 1-bit resized image into IMG_W-bit
// row words inside a two-bank frame buffer and replays completed frames row
// by row over a valid/ready stream.
//   clk, rst_n          : clock, synchronous active-low reset
//   pix_in, pix_valid   : pixel stream (no backpressure)
//   pix_last_in_line    : last pixel of a row (qualified by pix_valid)
//   pix_last_pix        : last pixel of a frame (qualified by pix_valid)
//   row_data/idx/last   : replayed row word, its row number, last-row flag
//   row_valid/row_ready : replay handshake
//   frame_drop          : pulse, incoming frame discarded (both banks full)
//   line_err            : pulse, row closed early by pix_last_in_line
//   drop_cnt            : saturating dropped-frame count
module resize_frame_packer
    import ipu_pkg::*;
#(
    parameter int unsigned IMG_W  = IPU_RESIZE_W,
    parameter int unsigned IMG_H  = IPU_RESIZE_H,
    parameter int unsigned ROW_AW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_in,
    input  logic              pix_valid,
    input  logic              pix_last_in_line,
    input  logic              pix_last_pix,
    output logic [IMG_W-1:0]  row_data,
    output logic [ROW_AW-1:0] row_idx,
    output logic              row_last,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              frame_drop,
    output logic              line_err,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned COL_AW = $clog2(IMG_W);
    localparam logic [COL_AW-1:0] COL_MAX = COL_AW'(IMG_W - 1);
    localparam logic [ROW_AW-1:0] ROW_MAX = ROW_AW'(IMG_H - 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RD   = 2'(RD);
    localparam logic [1:0] ST_SEND = 2'(SEND);

    // write side
    logic [IMG_W-1:0]  shift_q, shift_d;
    logic [COL_AW-1:0] col_q, col_d;
    logic [ROW_AW-1:0] row_q, row_d;
    logic              wr_bank_q, wr_bank_d;
    logic              drop_q, drop_d;
    logic              frame_drop_q, frame_drop_d;
    logic              line_err_q, line_err_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              full_set;
    logic              row_close;
    logic [IMG_W-1:0]  merged;
    logic              ram_we;

    // read side
    logic [1:0]        state_q, state_d;
    logic [ROW_AW-1:0] rd_row_q, rd_row_d;
    logic              rd_bank_q, rd_bank_d;
    logic              full_clr;
    logic              ram_re;
    logic [IMG_W-1:0]  ram_rdata;

    always_comb begin
        shift_d      = shift_q;
        col_d        = col_q;
        row_d        = row_q;
        wr_bank_d    = wr_bank_q;
        drop_d       = drop_q;
        frame_drop_d = 1'b0;
        line_err_d   = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        full_set     = 1'b0;
        ram_we       = 1'b0;
        // bits above col are still zero in shift_q, so unfilled columns write 0
        merged       = shift_q | (IMG_W'(pix_in) << col_q);
        row_close    = pix_last_in_line | pix_last_pix | (col_q == COL_MAX);

        if (pix_valid) begin
            if (drop_q) begin
                if (pix_last_pix) begin
                    drop_d = 1'b0;
                end
            end else if ((row_q == '0) && (col_q == '0) && full_q[wr_bank_q]) begin
                frame_drop_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                // a single-beat frame both starts and ends the discard here
                drop_d = ~pix_last_pix;
            end else if (row_close) begin
                ram_we     = 1'b1;
                shift_d    = '0;
                col_d      = '0;
                row_d      = (row_q == ROW_MAX) ? row_q : row_q + ROW_AW'(1);
                line_err_d = pix_last_in_line && (col_q != COL_MAX);
                if (pix_last_pix) begin
                    full_set  = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                    row_d     = '0;
                end
            end else begin
                shift_d = merged;
                col_d   = col_q + COL_AW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_row_d  = rd_row_q;
        rd_bank_d = rd_bank_q;
        full_clr  = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_row_d = '0;
                    state_d  = ST_RD;
                end
            end
            ST_RD: begin
                ram_re  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (row_ready) begin
                    if (rd_row_q == ROW_MAX) begin
                        full_clr  = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        state_d   = ST_IDLE;
                    end else begin
                        rd_row_d = rd_row_q + ROW_AW'(1);
                        state_d  = ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // set and clear always address different banks, so both apply
    always_comb begin
        full_d = full_q;
        if (full_set) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (full_clr) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            wr_bank_q    <= 1'b0;
            drop_q       <= 1'b0;
            frame_drop_q <= 1'b0;
            line_err_q   <= 1'b0;
            drop_cnt_q   <= '0;
            full_q       <= '0;
            state_q      <= ST_IDLE;
            rd_row_q     <= '0;
            rd_bank_q    <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wr_bank_q    <= wr_bank_d;
            drop_q       <= drop_d;
            frame_drop_q <= frame_drop_d;
            line_err_q   <= line_err_d;
            drop_cnt_q   <= drop_cnt_d;
            full_q       <= full_d;
            state_q      <= state_d;
            rd_row_q     <= rd_row_d;
            rd_bank_q    <= rd_bank_d;
        end
    end

    sdp_ram_1r1w #(
        .DEPTH (2 * IMG_H),
        .WIDTH (IMG_W),
        .AW    (ROW_AW + 1)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we),
        .wr_addr ({wr_bank_q, row_q}),
        .wr_data (merged),
        .rd_en   (ram_re),
        .rd_addr ({rd_bank_q, rd_row_q}),
        .rd_data (ram_rdata)
    );

    assign row_valid  = (state_q == ST_SEND);
    assign row_data   = ram_rdata;
    assign row_idx    = rd_row_q;
    assign row_last   = row_valid && (rd_row_q == ROW_MAX);
    assign frame_drop = frame_drop_q;
    assign line_err   = line_err_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_resize_frame_packer.sv
module tb_resize_frame_packer;

    localparam int IMG_W = 64;
    localparam int IMG_H = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_in;
    logic        pix_valid;
    logic        pix_last_in_line;
    logic        pix_last_pix;
    logic [63:0] row_data;
    logic [5:0]  row_idx;
    logic        row_last;
    logic        row_valid;
    logic        row_ready;
    logic        frame_drop;
    logic        line_err;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic [5:0]  idx;
        logic [63:0] data;
    } exp_row_t;

    exp_row_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_last   = 0;
    int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
    int drop_pulses = 0;
    int lerr_pulses = 0;
    bit prev_stall = 1'b0;

    resize_frame_packer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ROW_AW (6)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pix_in           (pix_in),
        .pix_valid        (pix_valid),
        .pix_last_in_line (pix_last_in_line),
        .pix_last_pix     (pix_last_pix),
        .row_data         (row_data),
        .row_idx          (row_idx),
        .row_last         (row_last),
        .row_valid        (row_valid),
        .row_ready        (row_ready),
        .frame_drop       (frame_drop),
        .line_err         (line_err),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        row_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       row_ready = 1'b0;
                1:       row_ready = 1'b1;
                default: row_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_drop) drop_pulses++;
            if (line_err)   lerr_pulses++;
            if (prev_stall) check_eq("valid_held", 64'(row_valid), 64'd1);
            if (row_valid) begin
                if (sb.size() == 0) begin
                    check_eq("row_without_expect", 64'(row_valid), 64'd0);
                end else begin
                    check_eq("row_data", row_data, sb[0].data);
                    if (row_ready) begin
                        check_eq("row_idx", 64'(row_idx), 64'(sb[0].idx));
                        check_eq("row_last", 64'(row_last), 64'(sb[0].idx == 6'd63));
                        void'(sb.pop_front());
                    end
                end
            end
            prev_stall = row_valid && !row_ready;
        end
    end

    // pat 0: (r+c)%2, pat 1: random words; short5 ends row 5 after 60 ones;
    // abort_after > 0 stops the stream after that many beats
    task automatic drive_frame(input int pat, input bit drop, input bit short5, input int abort_after);
        logic [63:0] w;
        int n;
        int beats;
        beats = 0;
        for (int r = 0; r < IMG_H; r++) begin
            n = IMG_W;
            if (short5 && r == 5) begin
                w = 64'h0FFF_FFFF_FFFF_FFFF;
                n = 60;
            end else if (pat == 0) begin
                for (int c = 0; c < IMG_W; c++) w[c] = 1'((r + c) % 2);
            end else begin
                w = {$urandom, $urandom};
            end
            for (int c = 0; c < n; c++) begin
                if (abort_after > 0 && beats == abort_after) begin
                    pix_valid = 1'b0;
                    pix_last_in_line = 1'b0;
                    pix_last_pix = 1'b0;
                    return;
                end
                pix_in           = w[c];
                pix_valid        = 1'b1;
                pix_last_in_line = (c == n - 1);
                pix_last_pix     = (r == IMG_H - 1) && (c == n - 1);
                if (pix_last_pix) t_last = cyc;
                @(posedge clk);
                #1;
                beats++;
            end
            if (!drop) sb.push_back('{idx: 6'(r), data: w});
        end
        pix_valid        = 1'b0;
        pix_last_in_line = 1'b0;
        pix_last_pix     = 1'b0;
        pix_in           = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int i;
        i = 0;
        while (sb.size() != 0 && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
        repeat (4) @(negedge clk);
        check_eq("idle_after_drain", 64'(row_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_row_valid"}, 64'(row_valid), 64'd0);
        check_eq({tag, "_row_data"}, row_data, 64'd0);
        check_eq({tag, "_row_idx"}, 64'(row_idx), 64'd0);
        check_eq({tag, "_row_last"}, 64'(row_last), 64'd0);
        check_eq({tag, "_frame_drop"}, 64'(frame_drop), 64'd0);
        check_eq({tag, "_line_err"}, 64'(line_err), 64'd0);
        check_eq({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pix_in = 1'b0;
        pix_valid = 1'b0;
        pix_last_in_line = 1'b0;
        pix_last_pix = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // 1: checkerboard frame, ready held high, first-row latency
        ready_mode = 1;
        lerr_pulses = 0;
        drive_frame(0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (row_valid) break;
        end
        check_eq("first_row_latency", 64'(cyc), 64'(t_last + 3));
        @(posedge clk);
        #1;
        wait_drain(400);
        check_eq("no_line_err_t1", 64'(lerr_pulses), 64'd0);

        // 2: random data, random backpressure
        ready_mode = 2;
        drive_frame(1, 1'b0, 1'b0, 0);
        wait_drain(2000);

        // 3: three back-to-back frames with the consumer stalled
        ready_mode = 0;
        drop_pulses = 0;
        drive_frame(1, 1'b0, 1'b0, 0);
        drive_frame(1, 1'b0, 1'b0, 0);
        drive_frame(0, 1'b1, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("drop_pulses", 64'(drop_pulses), 64'd1);
        check_eq("drop_cnt", 64'(drop_cnt), 64'd1);
        ready_mode = 1;
        wait_drain(2000);

        // 4: row 5 cut short after 60 pixels
        ready_mode = 1;
        lerr_pulses = 0;
        drive_frame(0, 1'b0, 1'b1, 0);
        wait_drain(400);
        check_eq("line_err_pulses", 64'(lerr_pulses), 64'd1);

        // 5: reset mid-readout and mid-frame, then a clean frame
        ready_mode = 2;
        drive_frame(1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 2000 && sb.size() >= 40; i++) @(posedge clk);
        #1;
        ready_mode = 0;
        drive_frame(1, 1'b0, 1'b0, 300);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        ready_mode = 1;
        drive_frame(1, 1'b0, 1'b0, 0);
        wait_drain(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
